window_gen_kxk: RTL



---
 rtl/canny_pkg.sv | 24 ++
 rtl/line_buffer.sv | 43 ++++
 rtl/window_gen_kxk.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/canny_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : canny_pkg
// Purpose  : Shared border-mode constants, window FSM encoding, counter widths
// Revision : 1.0 - initial release
// ============================================================================
package canny_pkg;

  localparam int BORDER_ZERO = 0;
  localparam int BORDER_REPL = 1;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } win_state_t;

  function automatic int cnt_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/line_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : line_buffer
// Purpose  : Enable-gated circular delay of DEPTH words (read-before-write)
// Revision : 1.0 - initial release
// ============================================================================
module line_buffer
  import canny_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 640
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_din,
  output logic [DATA_W-1:0] o_dout
);
  localparam int c_aw = cnt_w(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]   r_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_en) begin
      r_ptr <= (r_ptr == c_aw'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
    end
  end

  // Contents are never cleared; the window masking hides anything stale.
  always_ff @(posedge clk) begin
    if (i_en) begin
      r_mem[r_ptr] <= i_din;
    end
  end

  assign o_dout = r_mem[r_ptr];

endmodule
`default_nettype wire

// File: rtl/window_gen_kxk.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : window_gen_kxk
// Purpose  : K x K centred sliding window with zero/replicate border padding
// Revision : 1.0 - initial release
// ============================================================================
module window_gen_kxk
  import canny_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int IMG_W       = 640,
  parameter int IMG_H       = 512,
  parameter int K           = 3,
  parameter int BORDER_MODE = BORDER_ZERO
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [K*K*DATA_W-1:0] out_win,
  output logic                  out_sof,
  output logic                  out_eof
);
  localparam int c_r  = K / 2;
  localparam int c_d  = c_r * IMG_W + c_r;
  localparam int c_cw = cnt_w(IMG_W);
  localparam int c_rw = cnt_w(IMG_H);
  localparam int c_fw = cnt_w(c_d);
  localparam int c_kw = cnt_w(K);

  win_state_t            r_state, w_state_nxt;
  logic [c_cw-1:0]       r_in_col, r_out_col;
  logic [c_rw-1:0]       r_in_row, r_out_row;
  logic [c_fw-1:0]       r_flush_cnt;
  logic                  w_adv, w_emit;
  logic                  w_fill_done, w_in_last, w_out_last, w_flush_last;

  logic [DATA_W-1:0]     w_tap     [K];
  logic [DATA_W-1:0]     r_win     [K][K];
  logic [DATA_W-1:0]     w_win_nxt [K][K];
  logic [K*K*DATA_W-1:0] w_out_win;

  int                    w_row_src [K];
  int                    w_col_src [K];
  logic [c_kw-1:0]       w_row_sel [K];
  logic [c_kw-1:0]       w_col_sel [K];
  logic [K-1:0]          w_row_in, w_col_in;

  assign w_fill_done  = (r_in_row == c_rw'(c_r)) && (r_in_col == c_cw'(c_r - 1));
  assign w_in_last    = (r_in_row == c_rw'(IMG_H - 1)) && (r_in_col == c_cw'(IMG_W - 1));
  assign w_out_last   = (r_out_row == c_rw'(IMG_H - 1)) && (r_out_col == c_cw'(IMG_W - 1));
  assign w_flush_last = (r_flush_cnt == c_fw'(c_d - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b1;
    w_adv       = 1'b0;
    w_emit      = 1'b0;
    unique case (r_state)
      ST_FILL: begin
        w_adv = in_valid;
        if (in_valid && w_fill_done) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        w_adv  = in_valid;
        w_emit = in_valid;
        if (in_valid && w_in_last) w_state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        in_ready = 1'b0;
        w_adv    = 1'b1;
        w_emit   = 1'b1;
        if (w_flush_last) w_state_nxt = ST_FILL;
      end
      default: w_state_nxt = ST_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_col    <= '0;
      r_in_row    <= '0;
      r_out_col   <= '0;
      r_out_row   <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_adv && (r_state != ST_FLUSH)) begin
        if (r_in_col == c_cw'(IMG_W - 1)) begin
          r_in_col <= '0;
          r_in_row <= (r_in_row == c_rw'(IMG_H - 1)) ? '0 : r_in_row + 1'b1;
        end else begin
          r_in_col <= r_in_col + 1'b1;
        end
      end
      if (r_state == ST_FLUSH) begin
        r_flush_cnt <= w_flush_last ? '0 : r_flush_cnt + 1'b1;
      end
      if (w_emit) begin
        if (r_out_col == c_cw'(IMG_W - 1)) begin
          r_out_col <= '0;
          r_out_row <= (r_out_row == c_rw'(IMG_H - 1)) ? '0 : r_out_row + 1'b1;
        end else begin
          r_out_col <= r_out_col + 1'b1;
        end
      end
    end
  end

  // Row K-1 takes the newest pixel; each line buffer reaches one line further back.
  assign w_tap[K-1] = in_data;

  for (genvar gl = 0; gl < K - 1; gl++) begin : g_lb
    line_buffer #(
      .DATA_W (DATA_W),
      .DEPTH  (IMG_W)
    ) u_lb (
      .clk    (clk),
      .rst    (rst),
      .i_en   (w_adv),
      .i_din  (w_tap[K-1-gl]),
      .o_dout (w_tap[K-2-gl])
    );
  end

  for (genvar gi = 0; gi < K; gi++) begin : g_row
    for (genvar gj = 0; gj < K; gj++) begin : g_col
      if (gj == K - 1) begin : g_new
        assign w_win_nxt[gi][gj] = w_tap[gi];
      end else begin : g_shift
        assign w_win_nxt[gi][gj] = r_win[gi][gj+1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_win <= w_win_nxt;
    end
  end

  // Out-of-frame slots either read zero or are redirected to the clamped in-frame slot.
  always_comb begin
    for (int i = 0; i < K; i++) begin
      w_row_src[i] = int'(r_out_row) + i - c_r;
      w_row_in[i]  = (w_row_src[i] >= 0) && (w_row_src[i] < IMG_H);
      if (w_row_src[i] < 0) begin
        w_row_sel[i] = c_kw'(i - w_row_src[i]);
      end else if (w_row_src[i] >= IMG_H) begin
        w_row_sel[i] = c_kw'(i - (w_row_src[i] - (IMG_H - 1)));
      end else begin
        w_row_sel[i] = c_kw'(i);
      end
      w_col_src[i] = int'(r_out_col) + i - c_r;
      w_col_in[i]  = (w_col_src[i] >= 0) && (w_col_src[i] < IMG_W);
      if (w_col_src[i] < 0) begin
        w_col_sel[i] = c_kw'(i - w_col_src[i]);
      end else if (w_col_src[i] >= IMG_W) begin
        w_col_sel[i] = c_kw'(i - (w_col_src[i] - (IMG_W - 1)));
      end else begin
        w_col_sel[i] = c_kw'(i);
      end
    end
  end

  always_comb begin
    w_out_win = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        if ((w_row_in[i] && w_col_in[j]) || (BORDER_MODE == BORDER_REPL)) begin
          w_out_win[(i*K+j)*DATA_W +: DATA_W] = w_win_nxt[w_row_sel[i]][w_col_sel[j]];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      out_win   <= '0;
    end else begin
      out_valid <= w_emit;
      out_sof   <= w_emit && (r_out_row == '0) && (r_out_col == '0);
      out_eof   <= w_emit && w_out_last;
      if (w_emit) begin
        out_win <= w_out_win;
      end
    end
  end

endmodule
`default_nettype wire
